dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port data memory between the core load/store path (port 0) and a secondary master such as a program loader or debug port (port 1). One access per cycle reaches the memory, with a combinational grant and a registered read response one cycle later. A lock input allows bounded multi-beat bursts, and a burst counter forces release so neither master starves.

## Interface
- DATA_WIDTH, 32: width of data and address buses.
- MAX_BURST, 8: maximum consecutive locked beats per ownership; must be ≥1.
- clk_i  in  1  rising-edge clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mN_req_i  in  1  access request, N∈{0,1}; hold until granted.
- mN_we_i  in  1  1 = write, 0 = read.
- mN_addr_i  in  DATA_WIDTH  word address, passed unmodified to memory.
- mN_wdata_i  in  DATA_WIDTH  write data.
- mN_lock_i  in  1  keep ownership after this beat.
- mN_gnt_o  out  1  combinational; access accepted this cycle.
- mN_rvalid_o  out  1  read data valid, one cycle after granted read.
- mN_rdata_o  out  DATA_WIDTH  registered read data, held until next read to that port.
- mem_addr_o  out  DATA_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_we_o  out  1  memory write enable.
- mem_rdata_i  in  DATA_WIDTH  memory read data (combinational; valid only when mem_we_o=0).

## Operation
- FSM states IDLE, OWN0, OWN1; reset → IDLE.
- IDLE: winner chosen among requesting ports (priority rule below); winner's gnt=1, its addr/wdata/we drive memory. No request: mem_addr_o=0, mem_wdata_o=0, mem_we_o=0, all gnt=0.
- Granted beat with lock_i=1 and burst count+1 < MAX_BURST → OWNN, count increments. Otherwise → IDLE, count cleared.
- OWNN: only port N can be granted; other port's gnt=0 (stalls). Beat granted when mN_req_i=1. Exit to IDLE when owner drops req, drops lock on a granted beat, or count reaches MAX_BURST−1 on a granted beat (forced release).
- Forced release sets yield flag: next IDLE arbitration prefers the other port if it requests; flag clears on that arbitration.
- Read: on granted read, mem_rdata_i captured at clock edge into mN_rdata_o; mN_rvalid_o=1 for exactly the next cycle. Writes produce no rvalid.
- Only one gnt active per cycle; mem_we_o=1 only with a granted write.

## Timing
- Grant: 0 cycles (same cycle as req in IDLE or owning state).
- Read latency: rvalid/rdata 1 cycle after grant; back-to-back reads give rvalid every cycle.
- Reset values: all gnt_o 0, rvalid_o 0, rdata_o 0, mem_* 0, count 0, yield 0, RR pointer favours port 0.
- Reset mid-burst: immediate return to IDLE, pending rvalid dropped.
- Simultaneous requests in IDLE: resolved per priority rule; loser stalls, no lost request.
- MAX_BURST=1: lock ignored, FSM never leaves IDLE.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin in IDLE; last-granted port loses ties; yield flag overrides.
- Not defined: fixed priority, port 0 wins ties; yield flag still overrides after forced release.

## Structure
- Shared package: state encoding typedef (IDLE/OWN0/OWN1), port index constants M0/M1.
- One sub-module natural: dmem_arb_pick (2-way priority/round-robin selector with yield input).

## Test plan
- Reset with both req=1 → all outputs 0 until rst_i falls; first edge after reset grants port 0.
- m0 write 0xDEADBEEF @ addr 5, then m0 read addr 5 → mem_we_o=1 first cycle, m0_rvalid_o=1 next cycle after read with m0_rdata_o=0xDEADBEEF.
- Both request reads same cycle, no lock: fixed mode → m0,m0,... while m0 requests; RR_EN → alternating m0,m1,m0.
- m1 locked burst of 20 reads, MAX_BURST=8, m0 requesting → 8 m1 grants, m0 granted next, m1 resumes after.
- m0 lock, drops req mid-burst → FSM to IDLE, m1 granted same cycle it requests.
- rst_i asserted during OWN0 after granted read → rvalid not emitted, state IDLE, count 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t : FSM state encoding (IDLE, OWN0, OWN1)
//   M0 / M1     : port index constants (core path / secondary master)
package dmem_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t OWN0 = 2'd1;
  localparam arb_state_t OWN1 = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way request selector used when the arbiter is idle.
//   req0_i, req1_i : requests from port 0 / port 1
//   last_i         : port granted most recently
//   yield_i        : previous owner was forcibly released; favour the other port
//   gnt0_o, gnt1_o : one-hot (or zero) selection
// Build option: DMEM_ARB_RR_EN selects round-robin; otherwise port 0 wins ties.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic yield_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic prefer1;

`ifdef DMEM_ARB_RR_EN
  // The yield target is always the port that was not granted last, which is
  // exactly what round-robin already prefers.
  logic unused_yield;
  assign unused_yield = yield_i;
  assign prefer1      = (last_i == M0);
`else
  assign prefer1 = yield_i && (last_i == M0);
`endif

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && req1_i) begin
      gnt0_o = !prefer1;
      gnt1_o = prefer1;
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   mN_req/we/addr/wdata/lock_i : master N request channel (N = 0 core, 1 secondary)
//   mN_gnt_o                : combinational accept for this cycle
//   mN_rvalid_o, mN_rdata_o : registered read response, one cycle after a granted read
//   mem_addr/wdata/we_o     : memory request (zero when nothing is granted)
//   mem_rdata_i             : combinational memory read data
// Build option: DMEM_ARB_RR_EN enables round-robin idle arbitration.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [DATA_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic                  m0_lock_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [DATA_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic                  m1_lock_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  // Count holds beats already taken in the current ownership, at most MAX_BURST-1.
  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            yield_q, yield_d;
  logic            last_q, last_d;

  logic            pick_gnt0, pick_gnt1;
  logic            gnt0, gnt1;
  logic            beat, beat_port, beat_lock, can_extend;
  logic [31:0]     count_next;

  logic                  m0_rvalid_q, m1_rvalid_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

  dmem_arb_pick u_pick (
    .req0_i  (m0_req_i),
    .req1_i  (m1_req_i),
    .last_i  (last_q),
    .yield_i (yield_q),
    .gnt0_o  (pick_gnt0),
    .gnt1_o  (pick_gnt1)
  );

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      OWN0:    gnt0 = m0_req_i;
      OWN1:    gnt1 = m1_req_i;
      default: begin
        gnt0 = pick_gnt0;
        gnt1 = pick_gnt1;
      end
    endcase
    // Nothing reaches memory while reset is held.
    if (rst_i) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign beat       = gnt0 || gnt1;
  assign beat_port  = gnt1 ? M1 : M0;
  assign beat_lock  = gnt1 ? m1_lock_i : m0_lock_i;
  assign count_next = 32'(count_q) + 32'd1;
  assign can_extend = count_next < MAX_BURST;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    yield_d = yield_q;
    last_d  = last_q;
    if (beat) begin
      last_d = beat_port;
      if (state_q == IDLE) yield_d = 1'b0;
      if (beat_lock && can_extend) begin
        state_d = (beat_port == M1) ? OWN1 : OWN0;
        count_d = count_q + CntW'(1);
      end else begin
        state_d = IDLE;
        count_d = '0;
        // Burst limit hit while owning: let the other port in next.
        if (beat_lock && (state_q != IDLE)) yield_d = 1'b1;
      end
    end else if (state_q != IDLE) begin
      // Owner withdrew its request.
      state_d = IDLE;
      count_d = '0;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if (gnt0) begin
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
      mem_we_o    = m0_we_i;
    end else if (gnt1) begin
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_we_o    = m1_we_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      yield_q <= 1'b0;
      last_q  <= M1;  // round-robin starts out favouring port 0
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      yield_q <= yield_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= gnt0 && !m0_we_i;
      m1_rvalid_q <= gnt1 && !m1_we_i;
      if (gnt0 && !m0_we_i) m0_rdata_q <= mem_rdata_i;
      if (gnt1 && !m1_we_i) m1_rdata_q <= mem_rdata_i;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned MB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_we;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: word i starts as 0x1000_0000 + i.
  logic [DW-1:0] mem [64];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(32'h1000_0000 + i);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[5:0]];

  function automatic logic [DW-1:0] init_val(int a);
    return 32'(32'h1000_0000 + a);
  endfunction

  dmem_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_lock_i   (m0_lock),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_lock_i   (m1_lock),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata)
  );

  task automatic idle_all();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    m0_req = 1'b1; m0_addr = 32'd3; m0_wdata = 32'h11;
    m1_req = 1'b1; m1_addr = 32'd7; m1_wdata = 32'h22;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      n_bad++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt});
    end
    n_cmp++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid, m1_rvalid});
    end
    n_cmp++;
    if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    end
    n_cmp++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mem: got addr %h wdata %h we %b want 0", mem_addr, mem_wdata, mem_we);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || mem_addr !== 32'd3) begin
      n_bad++;
      $display("FAIL first_grant: got gnt %b addr %h want 10 addr 3", {m0_gnt, m1_gnt}, mem_addr);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== init_val(3) || m1_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL first_read: got rv %b%b data %h want 10 %h", m0_rvalid, m1_rvalid,
               m0_rdata, init_val(3));
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd5; m0_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (m0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEAD_BEEF)
    begin
      n_bad++;
      $display("FAIL write_beat: got gnt %b we %b addr %h wdata %h want 1 1 5 deadbeef",
               m0_gnt, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL write_no_rvalid: got %b want 0", m0_rvalid);
    end
    @(negedge clk);
    m0_we = 1'b0;
    #1;
    n_cmp++;
    if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin
      n_bad++; $display("FAIL read_beat: got gnt %b we %b want 1 0", m0_gnt, mem_we);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL read_back: got rv %b data %h want 1 deadbeef", m0_rvalid, m0_rdata);
    end
    @(negedge clk);
    idle_all();
    @(posedge clk);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL rdata_hold: got rv %b data %h want 0 deadbeef", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp;
    @(negedge clk);
    idle_all();
    m1_req = 1'b1; m1_addr = 32'd20;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL tie_prelude: got %b want 01", {m0_gnt, m1_gnt});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'd10;
      m1_req = 1'b1; m1_addr = 32'd20;
      #1;
`ifdef DMEM_ARB_RR_EN
      exp = (c % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp = 2'b10;
`endif
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== exp) begin
        n_bad++; $display("FAIL tie_cycle%0d: got %b want %b", c, {m0_gnt, m1_gnt}, exp);
      end
      if (c == 1) begin
        n_cmp++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== init_val(10)) begin
          n_bad++;
          $display("FAIL tie_rdata: got rv %b data %h want 1 %h", m0_rvalid, m0_rdata,
                   init_val(10));
        end
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_burst();
    int   beats;
    logic e0, e1;
    beats = 0;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clk);
      m1_req = 1'b1; m1_we = 1'b0; m1_lock = (beats < 19); m1_addr = 32'(32 + beats % 16);
      m0_req = (cyc >= 2 && cyc <= 9); m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'd7;
      #1;
      e0 = (cyc == 9);
      e1 = (cyc != 9);
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== {e0, e1}) begin
        n_bad++; $display("FAIL burst_cycle%0d: got %b want %b", cyc, {m0_gnt, m1_gnt}, {e0, e1});
      end
      if (e1) beats++;
      if (cyc == 2) begin
        n_cmp++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== init_val(32)) begin
          n_bad++;
          $display("FAIL burst_rdata: got rv %b data %h want 1 %h", m1_rvalid, m1_rdata,
                   init_val(32));
        end
      end
      if (cyc == 10) begin
        n_cmp++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== init_val(7) || m1_rvalid !== 1'b0) begin
          n_bad++;
          $display("FAIL burst_yield_read: got rv %b%b data %h want 10 %h", m0_rvalid,
                   m1_rvalid, m0_rdata, init_val(7));
        end
      end
    end
    @(negedge clk);
    idle_all();
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      n_bad++; $display("FAIL burst_end: got %b want 00", {m0_gnt, m1_gnt});
    end
  endtask

  task automatic test_lock_drop();
    logic [1:0] exp;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      m0_req = (cyc <= 3); m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 32'(cyc);
      m1_req = (cyc == 5); m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 32'd9;
      #1;
      exp = (cyc <= 3) ? 2'b10 : ((cyc == 4) ? 2'b00 : 2'b01);
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== exp) begin
        n_bad++; $display("FAIL lockdrop_cycle%0d: got %b want %b", cyc, {m0_gnt, m1_gnt}, exp);
      end
      if (cyc == 5) begin
        n_cmp++;
        if (mem_addr !== 32'd9) begin
          n_bad++; $display("FAIL lockdrop_addr: got %h want 9", mem_addr);
        end
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] exp;
    @(negedge clk);
    m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 32'd12;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL rmid_beat1: got %b want 10", {m0_gnt, m1_gnt});
    end
    @(negedge clk);
    m0_addr = 32'd13;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL rmid_beat2: got %b want 10", {m0_gnt, m1_gnt});
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_rvalid} !== 3'b000) begin
      n_bad++; $display("FAIL rmid_in_reset: got %b want 000", {m0_gnt, m1_gnt, m0_rvalid});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_rvalid: got %b want 0", m0_rvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    m1_req = 1'b1; m1_addr = 32'd14;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL rmid_idle: got %b want 01", {m0_gnt, m1_gnt});
    end
    // A fresh full-length burst proves the beat count restarted from zero.
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'd15;
      m1_req = 1'b1; m1_lock = 1'b0; m1_addr = 32'd14;
      #1;
      exp = (cyc <= 8) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== exp) begin
        n_bad++; $display("FAIL rmid_cycle%0d: got %b want %b", cyc, {m0_gnt, m1_gnt}, exp);
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_write_read();
    test_tie();
    test_burst();
    test_lock_drop();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
